// File: rtl/clause_distributor_pkg.sv
// Shared types and width helpers for the clause distributor.
package cdu_pkg;

  function automatic int var_w(input int lit_idx_max);
    return $clog2(lit_idx_max) + 1;
  endfunction

  function automatic int clause_w(input int cla_length, input int lit_idx_max);
    return cla_length * var_w(lit_idx_max);
  endfunction

  localparam int DEF_CLAUSE_W = clause_w(3, 1024);

  typedef logic [DEF_CLAUSE_W-1:0] clause_t;

  typedef enum logic [1:0] {IDLE, LOAD, DIST, DONE} cdu_state_e;

endpackage

// File: rtl/clause_distributor_rr_multi_grant.sv
// Combinational round-robin multi-grant: picks up to min(popcount(avail), remaining)
// engines scanning upward from rr_ptr with wrap, and ranks them in scan order.
module rr_multi_grant #(
  parameter int NUM_ENGINE = 4,
  parameter int CNT_W      = 11,
  localparam int PTR_W     = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1,
  localparam int RANK_W    = $clog2(NUM_ENGINE + 1)
) (
  input  logic [NUM_ENGINE-1:0]             i_avail,
  input  logic [PTR_W-1:0]                  i_rr_ptr,
  input  logic [CNT_W-1:0]                  i_remaining,
  output logic [NUM_ENGINE-1:0]             o_grant,
  output logic [NUM_ENGINE-1:0][RANK_W-1:0] o_rank,
  output logic [RANK_W-1:0]                 o_g,
  output logic [PTR_W-1:0]                  o_rr_ptr_nxt
);

  logic [RANK_W-1:0] w_lim;
  logic [PTR_W:0]    w_sum;
  logic [PTR_W-1:0]  w_idx;

  assign w_lim = (i_remaining >= CNT_W'(NUM_ENGINE)) ? RANK_W'(NUM_ENGINE)
                                                      : i_remaining[RANK_W-1:0];

  always_comb begin
    o_grant      = '0;
    o_rank       = '0;
    o_g          = '0;
    o_rr_ptr_nxt = i_rr_ptr;
    w_sum        = '0;
    w_idx        = '0;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      w_sum = {1'b0, i_rr_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_ENGINE))
        w_sum = w_sum - (PTR_W+1)'(NUM_ENGINE);
      w_idx = w_sum[PTR_W-1:0];
      if (i_avail[w_idx] && (o_g < w_lim)) begin
        o_grant[w_idx] = 1'b1;
        o_rank[w_idx]  = o_g;
        o_g            = o_g + 1'b1;
        o_rr_ptr_nxt   = (w_idx == PTR_W'(NUM_ENGINE - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clause_distributor.sv
// Buffers a clause set and streams it round-robin to NUM_ENGINE clause queues.
// Define CDU_UC_REPLAY_EN to redistribute the whole set on every new chosen UC.
module clause_distributor
  import cdu_pkg::*;
#(
  parameter int NUM_ENGINE  = 4,
  parameter int CLA_LENGTH  = 3,
  parameter int LIT_IDX_MAX = 1024,
  parameter int BUF_DEPTH   = 1024,
  localparam int VAR_W      = var_w(LIT_IDX_MAX),
  localparam int CLAUSE_W   = clause_w(CLA_LENGTH, LIT_IDX_MAX),
  localparam int CNT_W      = $clog2(BUF_DEPTH) + 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               load_valid_in,
  input  logic [CLAUSE_W-1:0]                clause_in,
  output logic                               load_ready_out,
  input  logic                               start_in,
  input  logic [NUM_ENGINE-1:0]              full_in,
  output logic [NUM_ENGINE-1:0][CLAUSE_W-1:0] clause_out,
  output logic [NUM_ENGINE-1:0]              grant_out,
  input  logic [VAR_W-1:0]                   chosen_uc_in,
  input  logic                               chosen_uc_valid_in,
  output logic [VAR_W-1:0]                   chosen_uc_out,
  output logic                               chosen_uc_valid_out,
  output logic                               empty_out,
  output logic                               done_out,
  output logic [CNT_W-1:0]                   clause_cnt_out
);

  localparam int ADDR_W = $clog2(BUF_DEPTH);
  localparam int PTR_W  = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int RANK_W = $clog2(NUM_ENGINE + 1);

  cdu_state_e                       r_state, w_state_nxt;
  logic [CNT_W-1:0]                 r_clause_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]                 r_rd_ptr, w_rd_nxt;
  logic [CNT_W-1:0]                 w_remaining;
  logic [PTR_W-1:0]                 r_rr_ptr, w_rr_nxt, w_rr_grant;
  logic [NUM_ENGINE-1:0]            w_grant;
  logic [NUM_ENGINE-1:0][RANK_W-1:0] w_rank;
  logic [RANK_W-1:0]                w_g;
  logic                             r_load_ready, w_load_ready_nxt;
  logic                             w_accept, w_dist, w_exhaust;
  logic [VAR_W-1:0]                 r_uc;
  logic                             r_uc_vld;
  logic [CLAUSE_W-1:0]              r_buf [BUF_DEPTH];
`ifdef CDU_UC_REPLAY_EN
  logic                             r_replay_pending, w_replay_nxt;
`endif

  assign w_accept    = load_valid_in && r_load_ready;
  assign w_dist      = (r_state == DIST);
  assign w_remaining = r_clause_cnt - r_rd_ptr;
  assign w_exhaust   = ((r_rd_ptr + CNT_W'(w_g)) == r_clause_cnt);

  rr_multi_grant #(
    .NUM_ENGINE (NUM_ENGINE),
    .CNT_W      (CNT_W)
  ) u_rr (
    .i_avail      (~full_in),
    .i_rr_ptr     (r_rr_ptr),
    .i_remaining  (w_remaining),
    .o_grant      (w_grant),
    .o_rank       (w_rank),
    .o_g          (w_g),
    .o_rr_ptr_nxt (w_rr_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clause_cnt;
    w_rd_nxt    = r_rd_ptr;
    w_rr_nxt    = r_rr_ptr;
`ifdef CDU_UC_REPLAY_EN
    w_replay_nxt = r_replay_pending;
`endif
    case (r_state)
      IDLE, LOAD: begin
        if (w_accept) begin
          w_cnt_nxt   = r_clause_cnt + 1'b1;
          w_state_nxt = LOAD;
        end
        // an empty set has nothing to stream, so skip straight to DONE
        if (start_in)
          w_state_nxt = (w_cnt_nxt == '0) ? DONE : DIST;
      end
      DIST: begin
        w_rd_nxt = r_rd_ptr + CNT_W'(w_g);
        if (w_g != '0)
          w_rr_nxt = w_rr_grant;
        if (w_exhaust)
          w_state_nxt = DONE;
`ifdef CDU_UC_REPLAY_EN
        if (chosen_uc_valid_in)
          w_replay_nxt = 1'b1;
`endif
      end
      DONE: begin
`ifdef CDU_UC_REPLAY_EN
        if (chosen_uc_valid_in || r_replay_pending) begin
          w_state_nxt  = DIST;
          w_rd_nxt     = '0;
          w_replay_nxt = 1'b0;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    w_load_ready_nxt = ((w_state_nxt == IDLE) || (w_state_nxt == LOAD)) &&
                       (w_cnt_nxt < CNT_W'(BUF_DEPTH));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_clause_cnt <= '0;
      r_rd_ptr     <= '0;
      r_rr_ptr     <= '0;
      r_load_ready <= 1'b0;
      r_uc         <= '0;
      r_uc_vld     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clause_cnt <= w_cnt_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_load_ready <= w_load_ready_nxt;
      r_uc_vld     <= chosen_uc_valid_in;
      if (chosen_uc_valid_in)
        r_uc <= chosen_uc_in;
    end
  end

`ifdef CDU_UC_REPLAY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_replay_pending <= 1'b0;
    else        r_replay_pending <= w_replay_nxt;
  end
`endif

  // storage is not reset; clause_cnt bounds which entries are meaningful
  always_ff @(posedge clock) begin
    if (w_accept)
      r_buf[r_clause_cnt[ADDR_W-1:0]] <= clause_in;
  end

  for (genvar k = 0; k < NUM_ENGINE; k++) begin : g_lane
    logic [ADDR_W-1:0]   w_addr;
    logic                r_gnt;
    logic [CLAUSE_W-1:0] r_cl;

    assign w_addr = r_rd_ptr[ADDR_W-1:0] + ADDR_W'(w_rank[k]);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_gnt <= 1'b0;
        r_cl  <= '0;
      end else begin
        r_gnt <= w_dist && w_grant[k];
        r_cl  <= (w_dist && w_grant[k]) ? r_buf[w_addr] : '0;
      end
    end

    assign grant_out[k]  = r_gnt;
    assign clause_out[k] = r_cl;
  end

  assign load_ready_out      = r_load_ready;
  assign chosen_uc_out       = r_uc;
  assign chosen_uc_valid_out = r_uc_vld;
  assign done_out            = (r_state == DONE);
  assign empty_out           = ((r_state == DIST) || (r_state == DONE)) && (r_rd_ptr == r_clause_cnt);
  assign clause_cnt_out      = r_clause_cnt;

endmodule

// File: tb/tb_clause_distributor.sv
// Scoreboard bench for clause_distributor: directed loads/starts push expected
// grant beats and UC pulses; a negedge monitor pops and compares them.
module tb_clause_distributor;
  localparam int N     = 4;
  localparam int VW    = 11;
  localparam int CW    = 33;
  localparam int DEPTH = 1024;
  localparam int CNTW  = 11;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 load_valid_in = 1'b0;
  logic [CW-1:0]        clause_in = '0;
  logic                 load_ready_out;
  logic                 start_in = 1'b0;
  logic [N-1:0]         full_in = '0;
  logic [N-1:0][CW-1:0] clause_out;
  logic [N-1:0]         grant_out;
  logic [VW-1:0]        chosen_uc_in = '0;
  logic                 chosen_uc_valid_in = 1'b0;
  logic [VW-1:0]        chosen_uc_out;
  logic                 chosen_uc_valid_out;
  logic                 empty_out;
  logic                 done_out;
  logic [CNTW-1:0]      clause_cnt_out;

  clause_distributor dut (
    .clock(clock), .reset(reset),
    .load_valid_in(load_valid_in), .clause_in(clause_in), .load_ready_out(load_ready_out),
    .start_in(start_in), .full_in(full_in),
    .clause_out(clause_out), .grant_out(grant_out),
    .chosen_uc_in(chosen_uc_in), .chosen_uc_valid_in(chosen_uc_valid_in),
    .chosen_uc_out(chosen_uc_out), .chosen_uc_valid_out(chosen_uc_valid_out),
    .empty_out(empty_out), .done_out(done_out), .clause_cnt_out(clause_cnt_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0]         g;
    logic [N-1:0][CW-1:0] cl;
  } gexp_t;

  gexp_t         gq[$];
  logic [VW-1:0] ucq[$];
  gexp_t         mon_e;
  logic [VW-1:0] mon_uc;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [CW-1:0] cl(input int i);
    return {11'(i), 11'(i + 100), 11'(i + 500)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (grant_out != '0) begin
      if (gq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: got %b expected no grant", grant_out);
      end else begin
        mon_e = gq.pop_front();
        check("grant_vec", 64'(grant_out), 64'(mon_e.g));
        for (int k = 0; k < N; k++)
          if (mon_e.g[k]) check($sformatf("clause_eng%0d", k), 64'(clause_out[k]), 64'(mon_e.cl[k]));
      end
    end
    if (chosen_uc_valid_out) begin
      if (ucq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_uc: got %0d expected no pulse", chosen_uc_out);
      end else begin
        mon_uc = ucq.pop_front();
        check("uc_value", 64'(chosen_uc_out), 64'(mon_uc));
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; load_valid_in = 1'b0; start_in = 1'b0;
    full_in = '0; chosen_uc_valid_in = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load_n(input int n, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      load_valid_in = 1'b1;
      clause_in     = cl(i);
      if (load_ready_out) acc++;
      tick();
    end
    load_valid_in = 1'b0;
  endtask

  task automatic push4(input logic [N-1:0] g, input int c0, input int c1, input int c2, input int c3);
    gexp_t e;
    int    c[N];
    c = '{c0, c1, c2, c3};
    e.g = g;
    for (int k = 0; k < N; k++) e.cl[k] = g[k] ? cl(c[k]) : '0;
    gq.push_back(e);
  endtask

  task automatic start_pulse();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic drain(input string name, input int lim);
    int n = 0;
    while (gq.size() != 0 && n < lim) begin tick(); n++; end
    check(name, 64'(gq.size()), 64'd0);
    gq.delete();
  endtask

  task automatic uc_pulse(input logic [VW-1:0] v);
    chosen_uc_in = v; chosen_uc_valid_in = 1'b1; ucq.push_back(v);
    tick();
    chosen_uc_valid_in = 1'b0;
  endtask

  initial begin
    int acc;
    // reset values
    #2 reset = 1'b0;
    #1;
    check("rst_grant", 64'(grant_out), 64'd0);
    check("rst_clause_nz", 64'(|clause_out), 64'd0);
    check("rst_ready", 64'(load_ready_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_empty", 64'(empty_out), 64'd0);
    check("rst_uc_vld", 64'(chosen_uc_valid_out), 64'd0);
    check("rst_cnt", 64'(clause_cnt_out), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("post_rst_ready", 64'(load_ready_out), 64'd1);

    // 10 clauses, no backpressure
    load_n(10, acc);
    check("t1_cnt", 64'(clause_cnt_out), 64'd10);
    push4(4'b1111, 0, 1, 2, 3);
    push4(4'b1111, 4, 5, 6, 7);
    push4(4'b0011, 8, 9, 0, 0);
    start_pulse();
    check("t1_no_grant_yet", 64'(grant_out), 64'd0);
    check("t1_not_empty", 64'(empty_out), 64'd0);
    tick();
    check("t1_first_grant_lat", 64'(grant_out), 64'hF);
    drain("t1_drain", 10);
    check("t1_done", 64'(done_out), 64'd1);
    check("t1_empty", 64'(empty_out), 64'd1);
    check("t1_ready_low", 64'(load_ready_out), 64'd0);

    // engines 0 and 2 full throughout
    do_reset();
    load_n(6, acc);
    full_in = 4'b0101;
    push4(4'b1010, 0, 0, 0, 1);
    push4(4'b1010, 0, 2, 0, 3);
    push4(4'b1010, 0, 4, 0, 5);
    start_pulse();
    drain("t2_drain", 10);
    check("t2_done", 64'(done_out), 64'd1);
    full_in = '0;

    // rr pointer movement: g=0 cycle, single grant, wrap from engine 1
    do_reset();
    load_n(7, acc);
    push4(4'b0001, 0, 0, 0, 0);
    push4(4'b1111, 4, 1, 2, 3);
    push4(4'b0110, 0, 5, 6, 0);
    full_in = 4'b1111;
    start_pulse();
    tick();
    full_in = 4'b1110;
    tick();
    full_in = 4'b0000;
    drain("t3_drain", 10);
    check("t3_done", 64'(done_out), 64'd1);

    // overfill the buffer
    do_reset();
    load_n(DEPTH + 3, acc);
    check("t4_accepted", 64'(acc), 64'(DEPTH));
    check("t4_cnt", 64'(clause_cnt_out), 64'(DEPTH));
    check("t4_ready_low", 64'(load_ready_out), 64'd0);
    for (int i = 0; i < DEPTH; i += 4) push4(4'b1111, i, i + 1, i + 2, i + 3);
    start_pulse();
    drain("t4_drain", 300);
    check("t4_done", 64'(done_out), 64'd1);

    // empty start, UC forwarding
    do_reset();
    start_pulse();
    check("t5_done_next", 64'(done_out), 64'd1);
    check("t5_empty", 64'(empty_out), 64'd1);
    chosen_uc_in = 11'd5; chosen_uc_valid_in = 1'b1; ucq.push_back(11'd5);
    tick();
    chosen_uc_in = 11'd9; ucq.push_back(11'd9);
    tick();
    chosen_uc_valid_in = 1'b0;
    tick(); tick(); tick();
    check("t5_uc_drain", 64'(ucq.size()), 64'd0);
    check("t5_uc_hold", 64'(chosen_uc_out), 64'd9);
    check("t5_done_again", 64'(done_out), 64'd1);
    ucq.delete();

    // UC after a 4-clause distribution
    do_reset();
    load_n(4, acc);
    push4(4'b1111, 0, 1, 2, 3);
    start_pulse();
    drain("t6_first", 10);
    check("t6_done", 64'(done_out), 64'd1);
`ifdef CDU_UC_REPLAY_EN
    push4(4'b1111, 0, 1, 2, 3);
    uc_pulse(11'd3);
    drain("t6_replay", 10);
    tick(); tick();
    check("t6_done_after_replay", 64'(done_out), 64'd1);
    // two UCs during DIST collapse into a single replay
    do_reset();
    load_n(8, acc);
    push4(4'b1111, 0, 1, 2, 3);
    push4(4'b1111, 4, 5, 6, 7);
    push4(4'b1111, 0, 1, 2, 3);
    push4(4'b1111, 4, 5, 6, 7);
    start_pulse();
    uc_pulse(11'd7);
    uc_pulse(11'd8);
    drain("t6_pending_replay", 20);
    tick(); tick(); tick(); tick();
    check("t6_single_replay_done", 64'(done_out), 64'd1);
`else
    uc_pulse(11'd3);
    tick(); tick(); tick(); tick();
    check("t6_done_terminal", 64'(done_out), 64'd1);
`endif
    check("t6_uc_drain", 64'(ucq.size()), 64'd0);
    ucq.delete();

    // asynchronous reset mid-distribution
    do_reset();
    load_n(10, acc);
    start_pulse();
    #2 reset = 1'b0;
    #1;
    check("t7_grant", 64'(grant_out), 64'd0);
    check("t7_clause_nz", 64'(|clause_out), 64'd0);
    check("t7_done", 64'(done_out), 64'd0);
    check("t7_empty", 64'(empty_out), 64'd0);
    check("t7_cnt", 64'(clause_cnt_out), 64'd0);
    check("t7_ready", 64'(load_ready_out), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("t7_idle_ready", 64'(load_ready_out), 64'd1);
    check("t7_idle_cnt", 64'(clause_cnt_out), 64'd0);
    tick(); tick();
    check("t7_no_grant", 64'(grant_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
